// File: rtl/datamem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data memory.
// Port 0 is the pipeline load/store stage, port 1 the host/loader.
module datamem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int P0_PRIO = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          p0_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   conflicts
);

    localparam logic W_FIXED = (P0_PRIO != 0);

    // r_last is 1 when port 1 holds the most recent grant
    logic          r_last;
    logic          r_own0;
    logic          r_own1;
    logic [DW-1:0] r_rd0;
    logic [DW-1:0] r_rd1;
    logic [15:0]   r_conf;

    logic w_open;
    logic w_tie;
    logic w_g0;
    logic w_g1;

    assign w_open = !hold && !reset;
    assign w_tie  = p0_req && p1_req;
    assign w_g0   = w_open && p0_req && (!p1_req || W_FIXED || r_last);
    assign w_g1   = w_open && p1_req && !w_g0;

    assign p0_gnt    = w_g0;
    assign p1_gnt    = w_g1;
    assign p0_stall  = p0_req && !w_g0;
    assign mem_en    = w_g0 || w_g1;
    assign mem_we    = (w_g0 && p0_we) || (w_g1 && p1_we);
    assign mem_addr  = w_g1 ? p1_addr : p0_addr;
    assign mem_wdata = w_g1 ? p1_wdata : p0_wdata;

    // Read data passes straight through in the return cycle, then is held
    assign p0_rvalid = r_own0;
    assign p1_rvalid = r_own1;
    assign p0_rdata  = r_own0 ? mem_rdata : r_rd0;
    assign p1_rdata  = r_own1 ? mem_rdata : r_rd1;
    assign conflicts = r_conf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= 1'b1;
            r_own0 <= 1'b0;
            r_own1 <= 1'b0;
            r_rd0  <= '0;
            r_rd1  <= '0;
            r_conf <= '0;
        end else begin
            if (w_g0 || w_g1)
                r_last <= w_g1;
            r_own0 <= w_g0 && !p0_we;
            r_own1 <= w_g1 && !p1_we;
            if (r_own0)
                r_rd0 <= mem_rdata;
            if (r_own1)
                r_rd1 <= mem_rdata;
            if (w_tie && !hold && r_conf != 16'hFFFF)
                r_conf <= r_conf + 16'd1;
        end
    end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter with a read-data scoreboard.
// A round-robin and a fixed-priority instance share one stimulus.
module tb_datamem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        hold;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        mem_init;

    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, p0_stall;
    logic [15:0] p0_rdata, p1_rdata, conflicts;
    logic        a_en, a_we;
    logic [15:0] a_addr, a_wd, a_rd;

    logic        f0_gnt, f0_rvalid, f1_gnt, f1_rvalid, f0_stall;
    logic [15:0] f0_rdata, f1_rdata, f_conf;
    logic        b_en, b_we;
    logic [15:0] b_addr, b_wd, b_rd;

    logic [15:0] mem_a [0:255];
    logic [15:0] mem_b [0:255];
    logic [15:0] ref_mem [0:255];
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    datamem_arbiter #(.AW(16), .DW(16), .P0_PRIO(0)) dut (
        .clk(clk), .reset(reset), .hold(hold),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .p0_stall(p0_stall),
        .mem_en(a_en), .mem_we(a_we), .mem_addr(a_addr),
        .mem_wdata(a_wd), .mem_rdata(a_rd), .conflicts(conflicts)
    );

    datamem_arbiter #(.AW(16), .DW(16), .P0_PRIO(1)) dut_fp (
        .clk(clk), .reset(reset), .hold(hold),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata),
        .p0_gnt(f0_gnt), .p0_rvalid(f0_rvalid), .p0_rdata(f0_rdata),
        .p1_gnt(f1_gnt), .p1_rvalid(f1_rvalid), .p1_rdata(f1_rdata),
        .p0_stall(f0_stall),
        .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr),
        .mem_wdata(b_wd), .mem_rdata(b_rd), .conflicts(f_conf)
    );

    function automatic logic [15:0] init_val(input logic [7:0] a);
        case (a)
            8'h10:   return 16'h1234;
            8'h11:   return 16'h5678;
            default: return {8'hA5, a};
        endcase
    endfunction

    // Synchronous single-port memories, one per arbiter instance
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= init_val(8'(i));
        end else if (a_en) begin
            if (a_we) mem_a[a_addr[7:0]] <= a_wd;
            else      a_rd <= mem_a[a_addr[7:0]];
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= init_val(8'(i));
        end else if (b_en) begin
            if (b_we) mem_b[b_addr[7:0]] <= b_wd;
            else      b_rd <= mem_b[b_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_rv(input string tag);
        logic e0, e1;
        e0 = (q0.size() != 0);
        e1 = (q1.size() != 0);
        chk({tag, "_rv0"}, 16'(p0_rvalid), 16'(e0));
        chk({tag, "_rv1"}, 16'(p1_rvalid), 16'(e1));
        if (e0) chk({tag, "_rd0"}, p0_rdata, q0.pop_front());
        if (e1) chk({tag, "_rd1"}, p1_rdata, q1.pop_front());
    endtask

    task automatic cyc(input string tag,
                       input logic r0, input logic w0,
                       input logic [15:0] a0, input logic [15:0] d0,
                       input logic r1, input logic w1,
                       input logic [15:0] a1, input logic [15:0] d1,
                       input logic hd, input logic e0, input logic e1);
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        hold = hd;
        #1;
        chk({tag, "_g0"}, 16'(p0_gnt), 16'(e0));
        chk({tag, "_g1"}, 16'(p1_gnt), 16'(e1));
        chk({tag, "_en"}, 16'(a_en), 16'(e0 | e1));
        chk({tag, "_we"}, 16'(a_we), 16'((e0 & w0) | (e1 & w1)));
        chk({tag, "_stall"}, 16'(p0_stall), 16'(r0 & !e0));
        if (e0 | e1) chk({tag, "_addr"}, a_addr, e1 ? a1 : a0);
        if (e0) begin
            if (w0) ref_mem[a0[7:0]] = d0;
            else    q0.push_back(ref_mem[a0[7:0]]);
        end
        if (e1) begin
            if (w1) ref_mem[a1[7:0]] = d1;
            else    q1.push_back(ref_mem[a1[7:0]]);
        end
        @(posedge clk);
        #1;
        check_rv(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        reset = 1'b1; mem_init = 1'b1; hold = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h10; p0_wdata = 16'h0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h11; p1_wdata = 16'h0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_g0", 16'(p0_gnt), 16'd0);
        chk("rst_g1", 16'(p1_gnt), 16'd0);
        chk("rst_en", 16'(a_en), 16'd0);
        chk("rst_conf", conflicts, 16'h0);
        chk("rst_rd0", p0_rdata, 16'h0);
        chk("rst_rv0", 16'(p0_rvalid), 16'd0);
        reset = 1'b0; mem_init = 1'b0;

        // Round-robin tie sequence, fixed-priority instance alongside
        for (int c = 0; c < 4; c++) begin
            cyc($sformatf("rr%0d", c), 1, 0, 16'h10, 16'h0,
                1, 0, 16'h11, 16'h0, 0, (c % 2) == 0, (c % 2) == 1);
            if (c < 3) begin
                chk("fp_g0", 16'(f0_gnt), 16'd1);
                chk("fp_g1", 16'(f1_gnt), 16'd0);
            end
            if (c == 2) chk("fp_conf", f_conf, 16'd3);
        end
        chk("rr_conf", conflicts, 16'd4);
        idle("drain0");

        // Single requester back to back, then held read data
        cyc("b2b0", 1, 0, 16'h10, 16'h0, 0, 0, 16'h0, 16'h0, 0, 1, 0);
        cyc("b2b1", 1, 0, 16'h11, 16'h0, 0, 0, 16'h0, 16'h0, 0, 1, 0);
        idle("drain1");
        chk("rd0_hold", p0_rdata, 16'h5678);

        // Cross-port write then read of the same address
        cyc("wr1", 0, 0, 16'h0, 16'h0, 1, 1, 16'h20, 16'hBEEF, 0, 0, 1);
        cyc("rd0", 1, 0, 16'h20, 16'h0, 0, 0, 16'h0, 16'h0, 0, 1, 0);
        idle("drain2");
        chk("rd0_beef", p0_rdata, 16'hBEEF);

        // Hold blocks new grants but not the outstanding read
        cyc("hrd", 1, 0, 16'h10, 16'h0, 0, 0, 16'h0, 16'h0, 0, 1, 0);
        cyc("hold", 0, 0, 16'h0, 16'h0, 1, 0, 16'h11, 16'h0, 1, 0, 0);
        cyc("unhold", 0, 0, 16'h0, 16'h0, 1, 0, 16'h11, 16'h0, 0, 0, 1);
        idle("drain3");
        chk("hold_conf", conflicts, 16'd4);

        // Saturate the conflict counter with competing writes
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 16'h30; p0_wdata = 16'h1;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 16'h30; p1_wdata = 16'h2;
        for (int c = 0; c < 65540; c++) @(posedge clk);
        #1;
        chk("sat_conf", conflicts, 16'hFFFF);
        @(posedge clk); #1;
        chk("sat_stick", conflicts, 16'hFFFF);

        // Reset lands on an outstanding read and drops it
        p1_req = 1'b0; p1_we = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h10;
        #1;
        chk("rrd_g0", 16'(p0_gnt), 16'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        p0_req = 1'b0;
        #1;
        chk("rrd_rv0", 16'(p0_rvalid), 16'd0);
        chk("rrd_conf", conflicts, 16'h0);
        chk("rrd_rd0", p0_rdata, 16'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle("post_rst");
        cyc("tie", 1, 0, 16'h11, 16'h0, 1, 0, 16'h10, 16'h0, 0, 1, 0);
        idle("drain4");
        chk("tie_conf", conflicts, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
